main_mem: RTL

Main-memory model and controller that sits directly downstream of the cache and serves its RAM port. It accepts one read or write request at a time, holds it for a fixed, parameterised access latency, then performs the array access and pulses `done`. It gives the cache and system benches a realistic multi-cycle backing store in place of a zero-latency array.

---
 rtl/main_mem.sv | 127 ++++++++++++
 1 files changed

// File: rtl/main_mem.sv
// Multi-cycle backing store: one read or write at a time, fixed LATENCY, done pulse on completion.
// Optional access statistics enabled with `define MAIN_MEM_STATS_EN.
module main_mem #(
    parameter int WIDTH     = 8,
    parameter int RAM_DEPTH = 256,
    parameter int LATENCY   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         re,
    input  logic                         we,
    input  logic [$clog2(RAM_DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  rd_count,
    output logic [15:0]                  wr_count
);

    localparam int AW = $clog2(RAM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [AW-1:0]    cap_addr;
    logic [WIDTH-1:0] cap_data;
    logic             cap_we;
    logic [WIDTH-1:0] mem [RAM_DEPTH];

    logic finishing;
    logic commit_wr;
    logic commit_rd;

    assign finishing = (state == S_WAIT) && (cnt == 4'd0);
    assign commit_wr = finishing && cap_we;
    assign commit_rd = finishing && !cap_we;

    // DONE accepts a new request exactly like IDLE, giving LATENCY+1 cycle throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= 4'd0;
            cap_addr <= '0;
            cap_data <= '0;
            cap_we   <= 1'b0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (we || re) begin
                        cap_addr <= addr;
                        cap_data <= data_in;
                        cap_we   <= we;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= S_WAIT;
                        busy     <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (!cap_we) begin
                            data_out <= mem[cap_addr];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Reset wipes the array so an aborted write can never leave data behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit_wr) begin
            mem[cap_addr] <= cap_data;
        end
    end

`ifdef MAIN_MEM_STATS_EN
    logic [15:0] rd_q;
    logic [15:0] wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= 16'd0;
            wr_q <= 16'd0;
        end else begin
            if (commit_rd && rd_q != 16'hFFFF) begin
                rd_q <= rd_q + 16'd1;
            end
            if (commit_wr && wr_q != 16'hFFFF) begin
                wr_q <= wr_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_q;
    assign wr_count = wr_q;
`else
    assign rd_count = 16'd0;
    assign wr_count = 16'd0;
`endif

endmodule
